// File: rtl/alu_uart_sequencer.sv
// Command sequencer between a UART rx/tx pair and a combinational ALU.
// It collects A, B and opcode bytes, latches the ALU result and sends it back as one byte.
module alu_uart_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int NB_TIMEOUT     = 24,
    parameter int TIMEOUT_CYCLES = 10000000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_overrun
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        CALC,
        SEND,
        WAIT_TX
    } state_t;

    localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    state_t                state_reg, state_next;
    logic [NB_DATA-1:0]    data_a_reg, data_a_next;
    logic [NB_DATA-1:0]    data_b_reg, data_b_next;
    logic [NB_OP-1:0]      operation_reg, operation_next;
    logic [NB_DATA-1:0]    tx_data_reg, tx_data_next;
    logic [NB_TIMEOUT-1:0] count_reg, count_next;
    logic                  tx_start_reg, tx_start_next;
    logic                  busy_reg, busy_next;
    logic                  timeout_reg, timeout_next;
    logic                  overrun_reg, overrun_next;

    always_comb begin
        state_next     = state_reg;
        data_a_next    = data_a_reg;
        data_b_next    = data_b_reg;
        operation_next = operation_reg;
        tx_data_next   = tx_data_reg;
        count_next     = count_reg;
        tx_start_next  = 1'b0;
        timeout_next   = 1'b0;
        overrun_next   = 1'b0;

        case (state_reg)
            WAIT_A: begin
                if (i_rx_done) begin
                    data_a_next = i_rx_data;
                    count_next  = '0;
                    state_next  = WAIT_B;
                end
            end
            WAIT_B, WAIT_OP: begin
                // A byte arriving on the expiry cycle still counts as in time.
                if (i_rx_done) begin
                    count_next = '0;
                    if (state_reg == WAIT_B) begin
                        data_b_next = i_rx_data;
                        state_next  = WAIT_OP;
                    end else begin
                        operation_next = i_rx_data[NB_OP-1:0];
                        state_next     = CALC;
                    end
                end else if (count_reg == TIMEOUT_LAST) begin
                    count_next   = '0;
                    timeout_next = 1'b1;
                    state_next   = WAIT_A;
                end else begin
                    count_next = count_reg + NB_TIMEOUT'(1);
                end
            end
            CALC: begin
                tx_data_next = i_alu_result;
                state_next   = SEND;
            end
            SEND: begin
                tx_start_next = 1'b1;
                state_next    = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_next = WAIT_A;
                end
            end
            default: state_next = WAIT_A;
        endcase

        // Bytes received while a result is in flight are dropped.
        if (i_rx_done && (state_reg == CALC || state_reg == SEND || state_reg == WAIT_TX)) begin
            overrun_next = 1'b1;
        end

        busy_next = (state_next == CALC) || (state_next == SEND) || (state_next == WAIT_TX);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg     <= WAIT_A;
            data_a_reg    <= '0;
            data_b_reg    <= '0;
            operation_reg <= '0;
            tx_data_reg   <= '0;
            count_reg     <= '0;
            tx_start_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            data_a_reg    <= data_a_next;
            data_b_reg    <= data_b_next;
            operation_reg <= operation_next;
            tx_data_reg   <= tx_data_next;
            count_reg     <= count_next;
            tx_start_reg  <= tx_start_next;
            busy_reg      <= busy_next;
            timeout_reg   <= timeout_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign o_data_a    = data_a_reg;
    assign o_data_b    = data_b_reg;
    assign o_operation = operation_reg;
    assign o_tx_data   = tx_data_reg;
    assign o_tx_start  = tx_start_reg;
    assign o_busy      = busy_reg;
    assign o_timeout   = timeout_reg;
    assign o_overrun   = overrun_reg;

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
Command sequencer that sits between the UART receiver/transmitter pair and the combinational ALU. It collects three received bytes in order (operand A, operand B, opcode), holds them on the ALU inputs, and latches the ALU result. It then launches one UART transmission with the result and returns to wait for the next command. An inter-byte timeout discards incomplete commands.

Parameters:
NB_DATA, 8, width of operands, result and UART data bytes.
NB_OP, 6, width of the ALU opcode field; taken from the low bits of the opcode byte.
NB_TIMEOUT, 24, width of the inter-byte timeout counter.
TIMEOUT_CYCLES, 10000000, idle clocks allowed between bytes of one command before abort.

Ports:
i_clock  in  1  system clock; all state changes on its rising edge.
i_reset  in  1  synchronous, active-high reset.
i_rx_done  in  1  one-cycle pulse: i_rx_data holds a valid received byte.
i_rx_data  in  NB_DATA  received byte.
i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
i_alu_result  in  NB_DATA  ALU result (combinational from o_data_a/o_data_b/o_operation).
o_data_a  out  NB_DATA  operand A to ALU (registered).
o_data_b  out  NB_DATA  operand B to ALU (registered).
o_operation  out  NB_OP  opcode to ALU (registered).
o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
o_tx_data  out  NB_DATA  latched result byte; stable from o_tx_start until next command's result.
o_busy  out  1  high in CALC, SEND, WAIT_TX.
o_timeout  out  1  one-cycle pulse when an incomplete command is aborted.
o_overrun  out  1  one-cycle pulse when i_rx_done arrives while busy (byte dropped).

Behaviour:
- All outputs registered. Reset (i_reset=1 at a clock edge): state WAIT_A; o_data_a, o_data_b, o_operation, o_tx_data = 0; o_tx_start, o_timeout, o_overrun = 0; timeout counter = 0. Reset takes priority over every event and aborts any state, including WAIT_TX (pending tx_done then ignored).
- States: WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX.
- WAIT_A: on i_rx_done, o_data_a <= i_rx_data, -> WAIT_B. No timeout in WAIT_A.
- WAIT_B: on i_rx_done, o_data_b <= i_rx_data, -> WAIT_OP.
- WAIT_OP: on i_rx_done, o_operation <= i_rx_data[NB_OP-1:0] (upper bits ignored), -> CALC.
- CALC: one cycle; ALU inputs stable; at its end o_tx_data <= i_alu_result, -> SEND.
- SEND: one cycle with o_tx_start=1, -> WAIT_TX.
- WAIT_TX: hold until i_tx_done, then -> WAIT_A. i_tx_done in any other state ignored.
- Latency: opcode i_rx_done sampled at edge t -> CALC during t..t+1, o_tx_start high and o_tx_data valid during cycle after edge t+2.
- Timeout: counter clears on entry to WAIT_B/WAIT_OP and on every accepted byte; increments each cycle in WAIT_B/WAIT_OP; when it equals TIMEOUT_CYCLES-1 with no i_rx_done that cycle -> WAIT_A, o_timeout pulses one cycle; operand registers keep their values. i_rx_done in the same cycle as expiry wins (byte accepted, no timeout).
- Overrun: i_rx_done in CALC, SEND or WAIT_TX -> byte dropped, o_overrun pulses one cycle, state unaffected.
- Opcode values are passed unchanged; undefined opcodes produce whatever the ALU returns (pass-through of A), still transmitted.
- Operand registers persist across commands until overwritten.

Test Plan:
- Reset, then bytes 0x05, 0x03, 0x20 -> o_operation=6'h20, one o_tx_start pulse with o_tx_data=0x08 two cycles after opcode byte; o_busy high until i_tx_done, then WAIT_A.
- Bytes 0x80, 0x02, 0x03 (SRA) -> o_tx_data=0xE0; then 0x80, 0x02, 0x02 (SRL) -> 0x20.
- Bytes 0x0F, 0x01, 0xE2 -> o_operation=6'h22 (upper bits dropped), o_tx_data=0x0E.
- TIMEOUT_CYCLES=16: send 0x11 then nothing -> o_timeout pulse 16 cycles later, state WAIT_A; next bytes 0x01,0x01,0x20 -> o_tx_data=0x02.
- Byte arrives while in WAIT_TX -> o_overrun pulse, no state change, no second o_tx_start; after i_tx_done new command works normally.
- Assert i_reset in WAIT_OP and again in WAIT_TX -> all outputs 0 next cycle, state WAIT_A, late i_tx_done ignored, no o_tx_start.
